// File: rtl/phys_reg_file_if.sv
// Shared core parameters and the register-read / execute
// port bundles of the physical register file.
package core_pkg;
  localparam int NUM_FUS   = 3;
  localparam int NUM_PREGS = 48;
  localparam int PW        = $clog2(NUM_PREGS);
endpackage

interface reg_read_reg_file_if;
  import core_pkg::*;

  logic [PW-1:0] src1_reg;
  logic [PW-1:0] src2_reg;
  logic [31:0]   src1_val;
  logic [31:0]   src2_val;

  modport rf (
    input  src1_reg,
    input  src2_reg,
    output src1_val,
    output src2_val
  );

  modport rr (
    output src1_reg,
    output src2_reg,
    input  src1_val,
    input  src2_val
  );
endinterface

interface execute_phys_reg_file_if;
  import core_pkg::*;

  logic          ex_valid;
  logic [PW-1:0] ex_dst_reg;
  logic [31:0]   ex_val;

  modport rf (
    input ex_valid,
    input ex_dst_reg,
    input ex_val
  );

  modport ex (
    output ex_valid,
    output ex_dst_reg,
    output ex_val
  );
endinterface

// File: rtl/phys_reg_file.sv
// Physical register file: one write and two read ports per
// FU pipe, same-cycle write bypass, register 0 hardwired to zero.
module phys_reg_file
  import core_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  reg_read_reg_file_if.rf     reg_read_if [NUM_FUS],
  execute_phys_reg_file_if.rf exec_if     [NUM_FUS]
);

  localparam logic [PW:0] PREGS = (PW+1)'(NUM_PREGS);

  logic [31:0]        phys_reg_file [NUM_PREGS];
  logic [NUM_FUS-1:0] wr_en;
  logic [PW-1:0]      wr_dst [NUM_FUS];
  logic [31:0]        wr_val [NUM_FUS];

  // Index names a real, writable register (not r0, not past the end).
  function automatic logic live(
    input logic [PW-1:0] idx
  );
    return (idx != '0) && ({1'b0, idx} < PREGS);
  endfunction

  for (genvar g = 0; g < NUM_FUS; g++) begin : g_wr
    assign wr_dst[g] = exec_if[g].ex_dst_reg;
    assign wr_val[g] = exec_if[g].ex_val;
    assign wr_en[g]  = exec_if[g].ex_valid &&
                       live(exec_if[g].ex_dst_reg);
  end

  // Later pipes' assignments land last, so the highest index wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NUM_PREGS; n++) begin
        phys_reg_file[n] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FUS; i++) begin
        if (wr_en[i]) begin
          phys_reg_file[wr_dst[i]] <= wr_val[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_FUS; g++) begin : g_rd
    logic [PW-1:0] r1;
    logic [PW-1:0] r2;
    logic [31:0]   v1;
    logic [31:0]   v2;

    assign r1 = reg_read_if[g].src1_reg;
    assign r2 = reg_read_if[g].src2_reg;

    always_comb begin
      v1 = '0;
      if (live(r1)) begin
        v1 = phys_reg_file[r1];
        for (int i = 0; i < NUM_FUS; i++) begin
          if (wr_en[i] && (wr_dst[i] == r1)) begin
            v1 = wr_val[i];
          end
        end
      end
    end

    always_comb begin
      v2 = '0;
      if (live(r2)) begin
        v2 = phys_reg_file[r2];
        for (int i = 0; i < NUM_FUS; i++) begin
          if (wr_en[i] && (wr_dst[i] == r2)) begin
            v2 = wr_val[i];
          end
        end
      end
    end

    assign reg_read_if[g].src1_val = v1;
    assign reg_read_if[g].src2_val = v2;
  end

endmodule

// File: tb/tb_phys_reg_file.sv
// Bench for phys_reg_file: directed literal cases plus random
// traffic checked every cycle against an array model.
module tb_phys_reg_file;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_read_reg_file_if     rr_if [NUM_FUS] ();
  execute_phys_reg_file_if ex_if [NUM_FUS] ();

  phys_reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .reg_read_if (rr_if),
    .exec_if     (ex_if)
  );

  logic [PW-1:0]      s1r [NUM_FUS];
  logic [PW-1:0]      s2r [NUM_FUS];
  logic [31:0]        s1v [NUM_FUS];
  logic [31:0]        s2v [NUM_FUS];
  logic [NUM_FUS-1:0] vld;
  logic [PW-1:0]      dst [NUM_FUS];
  logic [31:0]        val [NUM_FUS];

  for (genvar g = 0; g < NUM_FUS; g++) begin : g_map
    assign rr_if[g].src1_reg   = s1r[g];
    assign rr_if[g].src2_reg   = s2r[g];
    assign s1v[g]              = rr_if[g].src1_val;
    assign s2v[g]              = rr_if[g].src2_val;
    assign ex_if[g].ex_valid   = vld[g];
    assign ex_if[g].ex_dst_reg = dst[g];
    assign ex_if[g].ex_val     = val[g];
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [31:0] model [NUM_PREGS];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit writable(input logic [PW-1:0] idx);
    return int'(idx) != 0 && int'(idx) < NUM_PREGS;
  endfunction

  // What a read of idx must return this cycle: stored value,
  // overridden by the highest-numbered pipe writing it now.
  function automatic logic [31:0] exp_read(input logic [PW-1:0] idx);
    logic [31:0] r;
    if (!writable(idx)) return '0;
    r = model[int'(idx)];
    for (int i = 0; i < NUM_FUS; i++) begin
      if (vld[i] && dst[i] == idx) r = val[i];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NUM_PREGS; n++) model[n] = '0;
    end else begin
      for (int i = 0; i < NUM_FUS; i++) begin
        if (vld[i] && writable(dst[i])) model[int'(dst[i])] = val[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NUM_FUS; p++) begin
        check($sformatf("rd1[%0d] r%0d", p, s1r[p]), s1v[p], exp_read(s1r[p]));
        check($sformatf("rd2[%0d] r%0d", p, s2r[p]), s2v[p], exp_read(s2r[p]));
      end
      for (int n = 0; n < NUM_PREGS; n++) begin
        check($sformatf("arr[%0d]", n), dut.phys_reg_file[n], model[n]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NUM_FUS; i++) begin
      vld[i] = 1'b0;
      dst[i] = '0;
      val[i] = '0;
      s1r[i] = '0;
      s2r[i] = '0;
    end
  endtask

  task automatic wr(input int p, input int r, input logic [31:0] v);
    vld[p] = 1'b1;
    dst[p] = PW'(r);
    val[p] = v;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    for (int n = 0; n < NUM_PREGS; n++) model[n] = '0;
    tick();
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    s1r[0] = PW'(7);
    s2r[1] = PW'(47);
    #1;
    check("reset rd1", s1v[0], 32'd0);
    check("reset rd2", s2v[1], 32'd0);
    for (int n = 0; n < NUM_PREGS; n++) begin
      check($sformatf("reset arr[%0d]", n), dut.phys_reg_file[n], 32'd0);
    end

    wr(0, 7, 32'd12);
    tick();
    check("wr r7", dut.phys_reg_file[7], 32'd12);
    wr(0, 8, 32'd13);
    tick();
    check("wr r8", dut.phys_reg_file[8], 32'd13);
    idle();

    s1r[0] = PW'(7);
    s2r[0] = PW'(8);
    #1;
    check("rd r7", s1v[0], 32'd12);
    check("rd r8", s2v[0], 32'd13);

    s1r[0] = PW'(9);
    wr(0, 9, 32'hDEADBEEF);
    #1;
    check("bypass r9", s1v[0], 32'hDEADBEEF);
    tick();
    idle();
    check("arr r9", dut.phys_reg_file[9], 32'hDEADBEEF);

    wr(0, 0, 32'd55);
    #1;
    check("r0 bypass", s1v[0], 32'd0);
    tick();
    idle();
    #1;
    check("r0 arr", dut.phys_reg_file[0], 32'd0);
    check("r0 rd", s1v[0], 32'd0);

    wr(0, 5, 32'd1);
    wr(1, 5, 32'd2);
    s2r[2] = PW'(5);
    #1;
    check("conflict bypass", s2v[2], 32'd2);
    tick();
    idle();
    check("conflict arr", dut.phys_reg_file[5], 32'd2);

    wr(2, 50, 32'd77);
    s1r[2] = PW'(50);
    #1;
    check("oor bypass", s1v[2], 32'd0);
    tick();
    idle();
    s1r[1] = PW'(50);
    s2r[1] = PW'(63);
    #1;
    check("oor rd1", s1v[1], 32'd0);
    check("oor rd2", s2v[1], 32'd0);

    rst = 1'b0;
    wr(0, 3, 32'd99);
    tick();
    rst = 1'b1;
    idle();
    check("rst mid r3", dut.phys_reg_file[3], 32'd0);
    check("rst mid r7", dut.phys_reg_file[7], 32'd0);

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(63) != 0);
      for (int i = 0; i < NUM_FUS; i++) begin
        vld[i] = $urandom_range(2) != 0;
        dst[i] = PW'($urandom_range(7));
        if ($urandom_range(3) == 0) dst[i] = PW'($urandom);
        val[i] = $urandom;
        s1r[i] = PW'($urandom_range(7));
        s2r[i] = PW'($urandom);
      end
      tick();
    end

    idle();
    rst = 1'b1;
    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
